// File: rtl/axi_rd_arbiter.sv
// 2:1 round-robin read-channel arbiter merging IFU (m0) and LSU (m1) reads
// onto a single AXI-lite AR/R slave port, one read outstanding at a time.
module axi_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
) (
   input  logic              aclk,
   input  logic              aresetn,

   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   input  logic              m0_rready,

   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   input  logic              m1_rready,

   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AR   = 2'd1;
   localparam logic [1:0] ST_R    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic              prio_q, prio_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;

   logic any_req;
   logic grant;
   logic in_idle;
   logic in_r;
   logic route_m0;
   logic route_m1;

   assign any_req = m0_arvalid | m1_arvalid;
   // Tie goes to prio_q; otherwise the lone requester (m1 iff m0 is idle).
   assign grant   = (m0_arvalid & m1_arvalid) ? prio_q : m1_arvalid;

   // Combinational outputs are gated by aresetn so nothing leaks during reset.
   assign in_idle  = aresetn & (state_q == ST_IDLE);
   assign in_r     = aresetn & (state_q == ST_R);
   assign route_m0 = in_r & ~sel_q;
   assign route_m1 = in_r &  sel_q;

   assign m0_arready = in_idle & any_req & ~grant;
   assign m1_arready = in_idle & any_req &  grant;

   assign s_arvalid = (state_q == ST_AR);
   assign s_araddr  = araddr_q;
   assign s_rready  = (route_m0 & m0_rready) | (route_m1 & m1_rready);

   assign m0_rvalid = route_m0 & s_rvalid;
   assign m0_rdata  = route_m0 ? s_rdata : '0;
   assign m0_rresp  = route_m0 ? s_rresp : 2'b00;
   assign m1_rvalid = route_m1 & s_rvalid;
   assign m1_rdata  = route_m1 ? s_rdata : '0;
   assign m1_rresp  = route_m1 ? s_rresp : 2'b00;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      sel_d    = sel_q;
      prio_d   = prio_q;
      araddr_d = araddr_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               araddr_d = grant ? m1_araddr : m0_araddr;
               sel_d    = grant;
               prio_d   = ~grant;
               state_d  = ST_AR;
            end
         end
         ST_AR: begin
            if (s_arready) begin
               state_d = ST_R;
            end
         end
         ST_R: begin
            if (s_rvalid && s_rready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         prio_q   <= 1'b0;
         araddr_q <= '0;
      end else begin
         // NOTE: non-blocking updates so all registers sample the same pre-edge values.
         state_q  <= state_d;
         sel_q    <= sel_d;
         prio_q   <= prio_d;
         araddr_q <= araddr_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_axi_rd_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int FREE = 0, ADDR = 1, DATA = 2;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
   logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]        m0_rresp, m1_rresp, s_rresp;
   logic              s_arvalid, s_arready, s_rvalid, s_rready;

   int n_cmp = 0;
   int n_err = 0;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 aclk = ~aclk;

   task automatic check_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: which read is in flight, who owns it, who was served last.
   int          ph = FREE;
   logic        owner = 1'b0;
   logic        last_served = 1'b1;
   logic [31:0] held_addr = '0;

   always @(negedge aclk) begin : model
      logic win, any, data, e_srr;
      if (!aresetn) begin
         ph = FREE; owner = 1'b0; last_served = 1'b1; held_addr = '0;
      end
      any   = m0_arvalid || m1_arvalid;
      win   = (m0_arvalid && m1_arvalid) ? !last_served : m1_arvalid;
      data  = aresetn && ph == DATA;
      e_srr = data && (owner ? m1_rready : m0_rready);
      check_b("m m0_arready", m0_arready, aresetn && ph == FREE && any && !win);
      check_b("m m1_arready", m1_arready, aresetn && ph == FREE && any && win);
      check_b("m s_arvalid", s_arvalid, aresetn && ph == ADDR);
      check_w("m s_araddr", 64'(s_araddr), 64'(held_addr));
      check_b("m s_rready", s_rready, e_srr);
      check_b("m m0_rvalid", m0_rvalid, data && !owner && s_rvalid);
      check_b("m m1_rvalid", m1_rvalid, data && owner && s_rvalid);
      check_w("m m0_rdata", m0_rdata, (data && !owner) ? s_rdata : 64'd0);
      check_w("m m1_rdata", m1_rdata, (data && owner) ? s_rdata : 64'd0);
      check_w("m m0_rresp", 64'(m0_rresp), (data && !owner) ? 64'(s_rresp) : 64'd0);
      check_w("m m1_rresp", 64'(m1_rresp), (data && owner) ? 64'(s_rresp) : 64'd0);
      if (aresetn) begin
         case (ph)
            FREE: if (any) begin
               owner = win; last_served = win;
               held_addr = win ? m1_araddr : m0_araddr;
               ph = ADDR;
            end
            ADDR: if (s_arready) ph = DATA;
            default: if (s_rvalid && e_srr) ph = FREE;
         endcase
      end
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
      m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
      s_arready = 0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 0;
   endtask

   // Called one tick after a rising edge with the arbiter idle; T is this cycle.
   task automatic single_read(input logic [31:0] addr, input logic [63:0] data);
      s_arready = 1; m0_araddr = addr; m0_arvalid = 1; m0_rready = 1;
      #2;
      check_b("rd T m0_arready", m0_arready, 1'b1);
      check_b("rd T m1_arready", m1_arready, 1'b0);
      cyc(); m0_arvalid = 0;
      #2;
      check_b("rd T+1 s_arvalid", s_arvalid, 1'b1);
      check_w("rd T+1 s_araddr", 64'(s_araddr), 64'(addr));
      check_b("rd T+1 m1_rvalid", m1_rvalid, 1'b0);
      cyc(); s_rvalid = 1; s_rdata = data; s_rresp = 2'b00;
      #2;
      check_b("rd T+2 m0_rvalid", m0_rvalid, 1'b1);
      check_w("rd T+2 m0_rdata", m0_rdata, data);
      check_b("rd T+2 m1_rvalid", m1_rvalid, 1'b0);
      cyc(); s_rvalid = 0; s_rdata = '0;
      #2;
      check_b("rd T+3 m0_rvalid", m0_rvalid, 1'b0);
      check_b("rd T+3 s_arvalid", s_arvalid, 1'b0);
   endtask

   initial begin : stim
      int  n_grants;
      logic exp_m;
      idle_inputs();
      aresetn = 0;
      // Reset values with requests present: combinational outputs must stay 0.
      cyc();
      m0_arvalid = 1; m1_arvalid = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
      s_rdata = 64'hFFFF_0000_FFFF_0000;
      #2;
      check_b("rst m0_arready", m0_arready, 1'b0);
      check_b("rst m1_arready", m1_arready, 1'b0);
      check_b("rst m0_rvalid", m0_rvalid, 1'b0);
      check_w("rst m0_rdata", m0_rdata, 64'd0);
      check_b("rst s_rready", s_rready, 1'b0);
      check_b("rst s_arvalid", s_arvalid, 1'b0);
      check_w("rst s_araddr", 64'(s_araddr), 64'd0);
      cyc(); idle_inputs(); aresetn = 1;

      // Single IFU read.
      cyc();
      single_read(32'h8000_0000, 64'h0000_0013_0000_0297);

      // Simultaneous requests the cycle after reset: m0 wins, m1 next.
      cyc(); aresetn = 0;
      cyc(); aresetn = 1;
      cyc();
      m0_araddr = 32'h8000_0004; m0_arvalid = 1; m1_araddr = 32'h8000_1000; m1_arvalid = 1;
      s_arready = 1; m0_rready = 1; m1_rready = 1;
      #2;
      check_b("sim m0_arready", m0_arready, 1'b1);
      check_b("sim m1_arready T", m1_arready, 1'b0);
      cyc(); m0_arvalid = 0;
      #2;
      check_b("sim m1_arready T+1", m1_arready, 1'b0);
      check_w("sim s_araddr m0", 64'(s_araddr), 64'h8000_0004);
      cyc(); s_rvalid = 1; s_rdata = 64'h1111;
      #2;
      check_b("sim m1_arready T+2", m1_arready, 1'b0);
      check_b("sim m0_rvalid", m0_rvalid, 1'b1);
      cyc(); s_rvalid = 0;
      #2;
      check_b("sim m1_arready T+3", m1_arready, 1'b1);
      check_b("sim m0_arready T+3", m0_arready, 1'b0);
      cyc(); m1_arvalid = 0;
      #2;
      check_w("sim s_araddr m1", 64'(s_araddr), 64'h8000_1000);
      check_b("sim s_arvalid m1", s_arvalid, 1'b1);
      cyc(); s_rvalid = 1; s_rdata = 64'h2222;
      #2;
      check_b("sim m1_rvalid", m1_rvalid, 1'b1);
      check_w("sim m1_rdata", m1_rdata, 64'h2222);
      cyc(); s_rvalid = 0;

      // Continuous contention for six transactions.
      m0_arvalid = 1; m0_araddr = 32'h2000_0000;
      m1_arvalid = 1; m1_araddr = 32'h3000_0000;
      s_arready = 1; s_rvalid = 1; s_rdata = 64'h5A5A;
      n_grants = 0; exp_m = 0;
      for (int c = 0; c < 18; c++) begin
         #2;
         if (m0_arready || m1_arready) begin
            check_b($sformatf("rr grant%0d is m1", n_grants), m1_arready, 1'(n_grants % 2));
            exp_m = m1_arready;
            n_grants++;
         end
         if (s_arvalid)
            check_w("rr s_araddr", 64'(s_araddr), exp_m ? 64'h3000_0000 : 64'h2000_0000);
         cyc();
      end
      check_w("rr grant count", 64'(n_grants), 64'd6);

      // Backpressure on AR then on R, with m0 waiting.
      m0_arvalid = 0; m1_arvalid = 1; m1_araddr = 32'h4000_0010;
      s_arready = 0; s_rvalid = 0; m1_rready = 0;
      #2;
      check_b("bp m1_arready", m1_arready, 1'b1);
      cyc(); m1_arvalid = 0;
      for (int i = 0; i < 4; i++) begin
         #2;
         check_b("bp ar s_arvalid", s_arvalid, 1'b1);
         check_w("bp ar s_araddr", 64'(s_araddr), 64'h4000_0010);
         cyc();
      end
      s_arready = 1;
      #2;
      check_b("bp ar accept s_arvalid", s_arvalid, 1'b1);
      cyc();
      s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_0123_4567;
      m0_arvalid = 1; m0_araddr = 32'h5000_0000;
      for (int i = 0; i < 3; i++) begin
         #2;
         check_b("bp r m1_rvalid", m1_rvalid, 1'b1);
         check_w("bp r m1_rdata", m1_rdata, 64'hDEAD_BEEF_0123_4567);
         check_b("bp r s_rready", s_rready, 1'b0);
         check_b("bp r m0_arready", m0_arready, 1'b0);
         cyc();
      end
      m1_rready = 1;
      #2;
      check_b("bp r handshake s_rready", s_rready, 1'b1);
      cyc(); s_rvalid = 0; m1_rready = 0; m0_rready = 1;
      #2;
      check_b("bp idle m0_arready", m0_arready, 1'b1);
      check_b("bp idle m1_rvalid", m1_rvalid, 1'b0);

      // Error response forwarded unchanged, once.
      cyc(); m0_arvalid = 0; s_arready = 1;
      #2;
      check_w("err s_araddr", 64'(s_araddr), 64'h5000_0000);
      cyc(); s_rvalid = 1; s_rresp = 2'b10; s_rdata = '0;
      #2;
      check_b("err m0_rvalid", m0_rvalid, 1'b1);
      check_w("err m0_rresp", 64'(m0_rresp), 64'd2);
      cyc(); s_rvalid = 0; s_rresp = 2'b00;
      #2;
      check_b("err after m0_rvalid", m0_rvalid, 1'b0);
      check_b("err after s_arvalid", s_arvalid, 1'b0);

      // Asynchronous reset while in R.
      cyc(); m0_arvalid = 1; m0_araddr = 32'h6000_0000; s_arready = 1; m0_rready = 1;
      cyc(); m0_arvalid = 0;
      cyc(); m0_arvalid = 1; s_rvalid = 1; s_rdata = 64'h0123;
      #1;
      check_b("ar r m0_rvalid", m0_rvalid, 1'b1);
      check_b("ar r m0_arready", m0_arready, 1'b0);
      #1 aresetn = 0;
      #1;
      check_b("ar rst m0_rvalid", m0_rvalid, 1'b0);
      check_w("ar rst m0_rdata", m0_rdata, 64'd0);
      check_b("ar rst m0_arready", m0_arready, 1'b0);
      check_b("ar rst s_rready", s_rready, 1'b0);
      check_b("ar rst s_arvalid", s_arvalid, 1'b0);
      check_w("ar rst s_araddr", 64'(s_araddr), 64'd0);
      cyc(); idle_inputs(); aresetn = 1;
      cyc();
      single_read(32'h8000_0000, 64'h0000_0013_0000_0297);

      // Randomized traffic, with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         cyc();
         aresetn    = 1;
         m0_arvalid = 1'($urandom_range(0, 1));
         m1_arvalid = 1'($urandom_range(0, 1));
         m0_araddr  = $urandom;
         m1_araddr  = $urandom;
         m0_rready  = ($urandom_range(0, 3) != 0);
         m1_rready  = ($urandom_range(0, 3) != 0);
         s_arready  = 1'($urandom_range(0, 1));
         s_rvalid   = 1'($urandom_range(0, 1));
         s_rdata    = {$urandom, $urandom};
         s_rresp    = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) begin
            #1 aresetn = 0;
         end
      end
      cyc();
      aresetn = 1;
      idle_inputs();
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
